hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Consumes register addresses and result-source codes from the D/E/M/W pipeline registers.
- Drives the datapath's stall line and the forwarding-mux selects.
- Owns the busy timer of the multi-cycle mult/div unit, stalling D-stage HI/LO instructions until that unit is free.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Derives the D-stage stall from Tuse/Tnew comparisons against the E and M
// stages, selects forwarding sources for the D, E and M stage operands, and
// times the multi-cycle mult/div unit so HI/LO instructions wait in D.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic [4:0] A1_E,
  input  logic [4:0] A2_E,
  input  logic [4:0] A2_M,
  input  logic [4:0] A3_E,
  input  logic [4:0] A3_M,
  input  logic [4:0] A3_W,
  input  logic [2:0] RES_E,
  input  logic [2:0] RES_M,
  input  logic [2:0] RES_W,
  output logic       stall,
  output logic [2:0] MRD1_D,
  output logic [2:0] MRD2_D,
  output logic [2:0] MRD1_E,
  output logic [2:0] MRD2_E,
  output logic [2:0] MRD2_M,
  output logic       md_busy
);

  // Result-source codes; any other code behaves as "no write".
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC8 = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  // Forwarding mux selects.
  localparam logic [2:0] MF_RF   = 3'd0;
  localparam logic [2:0] MF_PC8E = 3'd1;
  localparam logic [2:0] MF_PC8M = 3'd2;
  localparam logic [2:0] MF_AOM  = 3'd3;
  localparam logic [2:0] MF_WDW  = 3'd4;

  logic [CW-1:0] cnt_r;
  logic          data_stall_s;
  logic          md_stall_s;

  // Register $0 is hard-wired, so it never matches a producer.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic logic writes(input logic [2:0] res);
    case (res)
      RES_ALU, RES_DM, RES_PC8, RES_MD: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Cycles until a producer sitting in E has its result ready.
  function automatic logic [1:0] tnew_e(input logic [2:0] res);
    case (res)
      RES_ALU, RES_MD: return 2'd1;
      RES_DM:          return 2'd2;
      default:         return 2'd0;
    endcase
  endfunction

  // Cycles until a producer sitting in M has its result ready.
  function automatic logic [1:0] tnew_m(input logic [2:0] res);
    case (res)
      RES_DM:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // A source operand must wait when a pending producer is later than its use.
  function automatic logic src_stall(input logic [4:0] addr, input logic [1:0] tuse,
                                     input logic [4:0] a3e, input logic [2:0] rese,
                                     input logic [4:0] a3m, input logic [2:0] resm);
    return (reg_match(addr, a3e) && writes(rese) && (tuse < tnew_e(rese))) ||
           (reg_match(addr, a3m) && writes(resm) && (tuse < tnew_m(resm)));
  endfunction

  // D-stage select; non-PC8 producers in E are left to stall or E forwarding.
  function automatic logic [2:0] fwd_d(input logic [4:0] addr,
                                       input logic [4:0] a3e, input logic [2:0] rese,
                                       input logic [4:0] a3m, input logic [2:0] resm);
    if (reg_match(addr, a3e) && (rese == RES_PC8)) begin
      return MF_PC8E;
    end else if (reg_match(addr, a3m) && (resm == RES_PC8)) begin
      return MF_PC8M;
    end else if (reg_match(addr, a3m) && ((resm == RES_ALU) || (resm == RES_MD))) begin
      return MF_AOM;
    end else begin
      return MF_RF;
    end
  endfunction

  // E-stage select; the nearest producer (M) wins over W.
  function automatic logic [2:0] fwd_e(input logic [4:0] addr,
                                       input logic [4:0] a3m, input logic [2:0] resm,
                                       input logic [4:0] a3w, input logic [2:0] resw);
    if (reg_match(addr, a3m) && (resm == RES_PC8)) begin
      return MF_PC8M;
    end else if (reg_match(addr, a3m) && ((resm == RES_ALU) || (resm == RES_MD))) begin
      return MF_AOM;
    end else if (reg_match(addr, a3w) && writes(resw)) begin
      return MF_WDW;
    end else begin
      return MF_RF;
    end
  endfunction

  // Stall and forwarding selects, evaluated in the same cycle as the inputs.
  always_comb begin
    data_stall_s = 1'b0;
    md_stall_s   = 1'b0;
    stall        = 1'b0;
    MRD1_D       = MF_RF;
    MRD2_D       = MF_RF;
    MRD1_E       = MF_RF;
    MRD2_E       = MF_RF;
    MRD2_M       = MF_RF;

    data_stall_s = src_stall(rs_D, tuse_rs_D, A3_E, RES_E, A3_M, RES_M) ||
                   src_stall(rt_D, tuse_rt_D, A3_E, RES_E, A3_M, RES_M);
    md_stall_s   = md_use_D && (md_busy || md_start_E);
    stall        = data_stall_s || md_stall_s;

    MRD1_D = fwd_d(rs_D, A3_E, RES_E, A3_M, RES_M);
    MRD2_D = fwd_d(rt_D, A3_E, RES_E, A3_M, RES_M);
    MRD1_E = fwd_e(A1_E, A3_M, RES_M, A3_W, RES_W);
    MRD2_E = fwd_e(A2_E, A3_M, RES_M, A3_W, RES_W);

    if (reg_match(A2_M, A3_W) && writes(RES_W)) begin
      MRD2_M = MF_WDW;
    end else begin
      MRD2_M = MF_RF;
    end
  end

  // Mult/div busy timer: a start reloads, otherwise count down and hold at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (md_start_E) begin
      cnt_r <= md_div_E ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign md_busy = (cnt_r != {CW{1'b0}});

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process drives one vector per
// cycle and queues its hand-computed outputs; the monitor pops and compares
// on each falling edge.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D;
  logic [1:0] tuse_rs_D, tuse_rt_D;
  logic       md_use_D, md_start_E, md_div_E;
  logic [4:0] A1_E, A2_E, A2_M, A3_E, A3_M, A3_W;
  logic [2:0] RES_E, RES_M, RES_W;
  logic       stall, md_busy;
  logic [2:0] MRD1_D, MRD2_D, MRD1_E, MRD2_E, MRD2_M;

  typedef struct {
    int         id;
    logic       stall;
    logic [2:0] d1, d2, e1, e2, m2;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid   = 0;

  hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .A1_E(A1_E), .A2_E(A2_E), .A2_M(A2_M),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .RES_E(RES_E), .RES_M(RES_M), .RES_W(RES_W),
    .stall(stall), .MRD1_D(MRD1_D), .MRD2_D(MRD2_D),
    .MRD1_E(MRD1_E), .MRD2_E(MRD2_E), .MRD2_M(MRD2_M), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int id, input string nm, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL vec%0d %s actual=%0d required=%0d", id, nm, act, req);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(cur.id, "stall",   {2'b00, stall},   {2'b00, cur.stall});
      chk(cur.id, "MRD1_D",  MRD1_D,           cur.d1);
      chk(cur.id, "MRD2_D",  MRD2_D,           cur.d2);
      chk(cur.id, "MRD1_E",  MRD1_E,           cur.e1);
      chk(cur.id, "MRD2_E",  MRD2_E,           cur.e2);
      chk(cur.id, "MRD2_M",  MRD2_M,           cur.m2);
      chk(cur.id, "md_busy", {2'b00, md_busy}, {2'b00, cur.busy});
    end
  end

  task automatic clear_inputs();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd0; tuse_rt_D = 2'd0;
    md_use_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
    A1_E = 5'd0; A2_E = 5'd0; A2_M = 5'd0;
    A3_E = 5'd0; A3_M = 5'd0; A3_W = 5'd0;
    RES_E = 3'd0; RES_M = 3'd0; RES_W = 3'd0;
  endtask

  // Advance to just after the next rising edge with all inputs idle.
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input logic s, input logic [2:0] d1, input logic [2:0] d2,
                            input logic [2:0] e1, input logic [2:0] e2,
                            input logic [2:0] m2, input logic b);
    exp_t e;
    e.id = vid; e.stall = s; e.d1 = d1; e.d2 = d2; e.e1 = e1; e.e2 = e2; e.m2 = m2; e.busy = b;
    sb.push_back(e);
    vid++;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();

    // Reset state; combinational selects still follow inputs under reset.
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); A2_M = 5'd5; A3_W = 5'd5; RES_W = 3'd1; A1_E = 5'd5;
            expect_out(1'b0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd4, 1'b0);
    step(); reset = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // Load-use: lw in E, consumer needs rs in E.
    step(); A3_E = 5'd2; RES_E = 3'd2; rs_D = 5'd2; tuse_rs_D = 2'd1;
            expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // lw in M, consumer uses in E: Tnew 1 is not later than Tuse 1.
    step(); A3_M = 5'd2; RES_M = 3'd2; rs_D = 5'd2; tuse_rs_D = 2'd1;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // lw in M, consumer needs it in D: must stall.
    step(); A3_M = 5'd2; RES_M = 3'd2; rs_D = 5'd2; tuse_rs_D = 2'd0;
            expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // lw in W, consumer in E picks up WD_W.
    step(); A1_E = 5'd2; A3_W = 5'd2; RES_W = 3'd2;
            expect_out(1'b0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 1'b0);
    // ALU result in M feeding a branch in D.
    step(); A3_M = 5'd3; RES_M = 3'd1; rs_D = 5'd3; rt_D = 5'd3;
            expect_out(1'b0, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0);
    // Same addu still in E: branch must stall.
    step(); A3_E = 5'd3; RES_E = 3'd1; rs_D = 5'd3; rt_D = 5'd3;
            expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // jal in E, jr $31 in D.
    step(); A3_E = 5'd31; RES_E = 3'd3; rs_D = 5'd31;
            expect_out(1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // $0 never forwards or stalls.
    step(); A3_M = 5'd0; RES_M = 3'd1; A3_E = 5'd0; RES_E = 3'd2; rs_D = 5'd0;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // Store data from W.
    step(); A2_M = 5'd5; A3_W = 5'd5; RES_W = 3'd1;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 1'b0);
    // E PC8 wins over M ALU for the D select.
    step(); A3_E = 5'd4; RES_E = 3'd3; A3_M = 5'd4; RES_M = 3'd1; rs_D = 5'd4; tuse_rs_D = 2'd2;
            expect_out(1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // M PC8 wins over W for both E selects.
    step(); A1_E = 5'd6; A2_E = 5'd6; A3_M = 5'd6; RES_M = 3'd3; A3_W = 5'd6; RES_W = 3'd1;
            expect_out(1'b0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 1'b0);
    // tuse 3 never stalls; MD result in M forwards as AO_M.
    step(); A3_E = 5'd7; RES_E = 3'd2; rt_D = 5'd7; tuse_rt_D = 2'd3;
            A3_M = 5'd8; RES_M = 3'd4; rs_D = 5'd8; A2_E = 5'd8;
            expect_out(1'b0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 1'b0);
    // NW and undefined result codes produce nothing.
    step(); A3_E = 5'd9; RES_E = 3'd0; A3_M = 5'd9; RES_M = 3'd5; rs_D = 5'd9;
            A1_E = 5'd9; A2_M = 5'd9; A3_W = 5'd9; RES_W = 3'd7;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // E load, use in M: equal timing, no stall.
    step(); A3_E = 5'd10; RES_E = 3'd2; rt_D = 5'd10; tuse_rt_D = 2'd2;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // MD read in E, rt needed in D: stall.
    step(); A3_E = 5'd11; RES_E = 3'd4; rt_D = 5'd11; tuse_rt_D = 2'd0;
            expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // ALU in E, rt needed in E: no stall.
    step(); A3_E = 5'd11; RES_E = 3'd1; rt_D = 5'd11; tuse_rt_D = 2'd1;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    // M load does not forward in E; falls through to W PC8.
    step(); A2_E = 5'd12; A3_M = 5'd12; RES_M = 3'd2; A3_W = 5'd12; RES_W = 3'd3;
            expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 1'b0);

    // Divide with mflo waiting in D: start cycle plus 10 busy cycles stall.
    step(); md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
            expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(); md_use_D = 1'b1; expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    step(); md_use_D = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // Multiply: 5 busy cycles; HI/LO user stalls only while busy.
    step(); md_start_E = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); md_use_D = 1'b1; expect_out(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // A mult started during a divide reloads the shorter count.
    step(); md_start_E = 1'b1; md_div_E = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    step(); md_start_E = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    // Reset mid-divide: asserted while cnt = 6, busy drops before any edge.
    step(); md_start_E = 1'b1; md_div_E = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    end
    step(); reset = 1'b0; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); reset = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); md_use_D = 1'b1; expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step(); expect_out(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    step();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
